// File: rtl/stream_unpacker.sv
// stream_unpacker: width-down converter. Takes a packed word of num_elems_p
// elements over valid/ready and emits them one per transfer on a registered
// valid/ready output. Supports element order selection, partial-word length
// and frame-end propagation on the final element of a word.
module stream_unpacker #(
  parameter int elem_width_p = 2,
  parameter int num_elems_p  = 4,
  parameter bit msb_first_p  = 1'b0,
  parameter int bus_width_p  = elem_width_p * num_elems_p,
  parameter int len_width_p  = $clog2(num_elems_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [bus_width_p-1:0]  packed_i,
  input  logic [len_width_p-1:0]  len_i,
  input  logic                    last_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [elem_width_p-1:0] unpacked_o,
  output logic                    last_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  // Index wide enough to address every element; never below one bit.
  localparam int idx_width_lp = (num_elems_p > 2) ? $clog2(num_elems_p) : 1;

  // Captured input word: payload, effective length and frame-end flag.
  typedef struct packed {
    logic [bus_width_p-1:0] data;
    logic [len_width_p-1:0] len;
    logic                   last;
  } word_t;

  typedef enum logic {st_idle, st_busy} state_e;

  state_e                                 state_q, state_d;
  word_t                                  word_r;
  logic [idx_width_lp-1:0]                idx_r;
  logic [len_width_p-1:0]                 len_eff;
  logic [num_elems_p-1:0][elem_width_p-1:0] elems;
  logic                                   busy;
  logic                                   fire_in;
  logic                                   load;
  logic                                   at_end;
  logic                                   final_load;

  assign busy       = (state_q == st_busy);
  // Output register may take a new element when empty or being drained.
  assign load       = busy && (!valid_o || ready_i);
  // Index is always below len, so zero-extending it is exact.
  assign at_end     = (len_width_p'(idx_r) == word_r.len - len_width_p'(1));
  assign final_load = load && at_end;
  // Accept the next word in the same cycle the current one finishes,
  // which keeps back-to-back words bubble-free.
  assign ready_o    = !busy || final_load;
  assign fire_in    = valid_i && ready_o;

  // Zero or out-of-range lengths mean a full word.
  always_comb begin
    len_eff = len_i;
    if (len_i == '0 || len_i > len_width_p'(num_elems_p))
      len_eff = len_width_p'(num_elems_p);
  end

  // Element k view of the buffered word, in the configured order.
  for (genvar k = 0; k < num_elems_p; k++) begin : g_elem
    localparam int pos_lp = msb_first_p ? (num_elems_p - 1 - k) : k;
    assign elems[k] = word_r.data[pos_lp*elem_width_p +: elem_width_p];
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= st_idle;
    else         state_q <= state_d;
  end

  // Next state: busy from capture until the final load of a word, unless
  // a new word is captured alongside that final load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle: if (fire_in)                 state_d = st_busy;
      st_busy: if (final_load && !fire_in)  state_d = st_idle;
      default:                              state_d = st_idle;
    endcase
  end

  // Word buffer and element index; index parks at 0 after the last element
  // so it never runs past num_elems_p-1.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      word_r <= '0;
      idx_r  <= '0;
    end else if (fire_in) begin
      word_r <= '{data: packed_i, len: len_eff, last: last_i};
      idx_r  <= '0;
    end else if (final_load) begin
      idx_r  <= '0;
    end else if (load) begin
      idx_r  <= idx_r + idx_width_lp'(1);
    end
  end

  // Output register: load the current element, or drop valid once taken.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      unpacked_o <= '0;
      last_o     <= 1'b0;
      valid_o    <= 1'b0;
    end else if (load) begin
      unpacked_o <= elems[idx_r];
      last_o     <= word_r.last && at_end;
      valid_o    <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_unpacker.sv
// Bench for stream_unpacker: LSB-first and MSB-first 2x4 instances share
// stimulus and are checked against a queue-based reference; a 4x3 instance
// covers the mid-word reset case.
module tb_stream_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Shared stimulus for the 2x4 instances.
  logic       rst;
  logic [7:0] ab_packed;
  logic [2:0] ab_len;
  logic       ab_last, ab_valid, ab_rdy;
  logic       ready_a, valid_a, last_a, ready_b, valid_b, last_b;
  logic [1:0] data_a, data_b;

  // 4x3 instance.
  logic        c_rst;
  logic [11:0] c_packed;
  logic [1:0]  c_len;
  logic        c_last, c_valid, c_rdy, c_ready, c_valid_o, c_last_o;
  logic [3:0]  c_data;

  stream_unpacker #(.elem_width_p(2), .num_elems_p(4), .msb_first_p(1'b0)) u_a (
    .clk_i(clk), .reset_i(rst), .packed_i(ab_packed), .len_i(ab_len), .last_i(ab_last),
    .valid_i(ab_valid), .ready_o(ready_a), .unpacked_o(data_a), .last_o(last_a),
    .valid_o(valid_a), .ready_i(ab_rdy));

  stream_unpacker #(.elem_width_p(2), .num_elems_p(4), .msb_first_p(1'b1)) u_b (
    .clk_i(clk), .reset_i(rst), .packed_i(ab_packed), .len_i(ab_len), .last_i(ab_last),
    .valid_i(ab_valid), .ready_o(ready_b), .unpacked_o(data_b), .last_o(last_b),
    .valid_o(valid_b), .ready_i(ab_rdy));

  stream_unpacker #(.elem_width_p(4), .num_elems_p(3), .msb_first_p(1'b0)) u_c (
    .clk_i(clk), .reset_i(c_rst), .packed_i(c_packed), .len_i(c_len), .last_i(c_last),
    .valid_i(c_valid), .ready_o(c_ready), .unpacked_o(c_data), .last_o(c_last_o),
    .valid_o(c_valid_o), .ready_i(c_rdy));

  // Reference: element count of a word and the value of element k.
  function automatic int model_len(input logic [2:0] l);
    return (l == 0 || l > 4) ? 4 : int'(l);
  endfunction

  function automatic logic [1:0] model_elem(input logic [7:0] w, input int k, input bit msb);
    int pos;
    pos = msb ? 3 - k : k;
    return 2'((int'(w) / (1 << (2 * pos))) % 4);
  endfunction

  // Scoreboard: expected {last, data} per instance.
  logic [2:0] qa[$];
  logic [2:0] qb[$];
  logic       stall_a = 1'b0, stall_b = 1'b0;
  logic [2:0] hold_a, hold_b;

  always @(negedge clk) begin
    int le;
    logic [2:0] e;
    if (!rst) begin
      if (ab_valid && ready_a) begin
        le = model_len(ab_len);
        for (int k = 0; k < le; k++) qa.push_back({ab_last && k == le - 1, model_elem(ab_packed, k, 1'b0)});
      end
      if (ab_valid && ready_b) begin
        le = model_len(ab_len);
        for (int k = 0; k < le; k++) qb.push_back({ab_last && k == le - 1, model_elem(ab_packed, k, 1'b1)});
      end
      if (stall_a) begin
        chk("a_hold_v", valid_a, 1);
        chk("a_hold_d", data_a, hold_a[1:0]);
        chk("a_hold_l", last_a, hold_a[2]);
      end
      if (stall_b) begin
        chk("b_hold_v", valid_b, 1);
        chk("b_hold_d", data_b, hold_b[1:0]);
        chk("b_hold_l", last_b, hold_b[2]);
      end
      stall_a = valid_a && !ab_rdy;
      hold_a  = {last_a, data_a};
      stall_b = valid_b && !ab_rdy;
      hold_b  = {last_b, data_b};
      if (valid_a && ab_rdy) begin
        if (qa.size() == 0) chk("a_extra", valid_a, 0);
        else begin
          e = qa.pop_front();
          chk("a_data", data_a, e[1:0]);
          chk("a_last", last_a, e[2]);
        end
      end
      if (valid_b && ab_rdy) begin
        if (qb.size() == 0) chk("b_extra", valid_b, 0);
        else begin
          e = qb.pop_front();
          chk("b_data", data_b, e[1:0]);
          chk("b_last", last_b, e[2]);
        end
      end
    end
  end

  // Wait (bounded) for the cycle in which the A instance accepts.
  task automatic wait_fire_ab();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_a) break;
    end
    if (!ready_a) chk("ab_fire_timeout", ready_a, 1);
  endtask

  logic [1:0] exp_a8 [8];
  logic [1:0] exp_b8 [8];
  bit         stop_rdy;

  initial begin
    rst = 1'b1; c_rst = 1'b1;
    ab_packed = '0; ab_len = '0; ab_last = 1'b0; ab_valid = 1'b0; ab_rdy = 1'b1;
    c_packed = '0; c_len = '0; c_last = 1'b0; c_valid = 1'b0; c_rdy = 1'b1;
    #1;
    chk("rst_valid", valid_a, 0);
    chk("rst_ready", ready_a, 1);
    chk("rst_data", data_a, 0);
    chk("rst_last", last_a, 0);
    chk("rst_c_ready", c_ready, 1);
    #11; rst = 1'b0; c_rst = 1'b0;

    // Full word E4, both orders, latency and ready timing.
    @(posedge clk); #1;
    ab_valid = 1'b1; ab_packed = 8'hE4; ab_len = 3'd0; ab_last = 1'b0;
    @(negedge clk); chk("t1_ready_idle", ready_a, 1);
    @(posedge clk); #1; ab_valid = 1'b0;
    @(negedge clk); chk("t1_latency", valid_a, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_valid", valid_a, 1);
      chk("t1_a", data_a, k);
      chk("t1_b", data_b, 3 - k);
      chk("t1_last", last_a, 0);
      chk("t1_ready", ready_a, (k >= 2) ? 1 : 0);
    end
    @(negedge clk); chk("t1_idle", valid_a, 0);

    // Partial word: two elements, last on the second.
    @(posedge clk); #1;
    ab_valid = 1'b1; ab_packed = 8'hE4; ab_len = 3'd2; ab_last = 1'b1;
    wait_fire_ab();
    @(posedge clk); #1; ab_valid = 1'b0;
    @(negedge clk); chk("t3_latency", valid_a, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t3_valid", valid_a, 1);
      chk("t3_a", data_a, k);
      chk("t3_last", last_a, (k == 1) ? 1 : 0);
      chk("t3_ready", ready_a, 1);
    end
    @(negedge clk); chk("t3_idle", valid_a, 0);

    // Back-to-back words with no bubble.
    exp_a8 = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    exp_b8 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    @(posedge clk); #1;
    ab_valid = 1'b1; ab_packed = 8'h1B; ab_len = 3'd0; ab_last = 1'b0;
    wait_fire_ab();
    @(posedge clk); #1; ab_packed = 8'hE4;
    @(negedge clk);
    chk("t4_latency", valid_a, 0);
    chk("t4_busy", ready_a, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t4_valid", valid_a, 1);
      chk("t4_a", data_a, exp_a8[k]);
      chk("t4_b", data_b, exp_b8[k]);
      if (k == 2) begin
        chk("t4_accept", ready_a, 1);
        @(posedge clk); #1; ab_valid = 1'b0;
      end
    end
    @(negedge clk); chk("t4_idle", valid_a, 0);

    // Random words under random backpressure.
    stop_rdy = 1'b0;
    fork
      begin
        for (int w = 0; w < 64; w++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          ab_valid  = 1'b1;
          ab_packed = 8'($urandom);
          ab_len    = 3'($urandom_range(0, 7));
          ab_last   = 1'($urandom);
          wait_fire_ab();
          @(posedge clk); #1; ab_valid = 1'b0;
        end
        stop_rdy = 1'b1;
      end
      begin
        while (!stop_rdy) begin
          @(posedge clk); #1;
          ab_rdy = 1'($urandom);
        end
      end
    join
    ab_rdy = 1'b1;
    for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    chk("a_drain", qa.size(), 0);
    chk("b_drain", qb.size(), 0);

    // 4x3: reset in the middle of a word discards it.
    @(posedge clk); #1;
    c_valid = 1'b1; c_packed = 12'hA5C; c_len = 2'd0; c_last = 1'b0;
    @(negedge clk); chk("c_ready_idle", c_ready, 1);
    @(posedge clk); #1; c_valid = 1'b0;
    @(negedge clk); chk("c_latency", c_valid_o, 0);
    @(negedge clk);
    chk("c_e0_valid", c_valid_o, 1);
    chk("c_e0", c_data, 4'hC);
    @(posedge clk); #2; c_rst = 1'b1; #1;
    chk("c_rst_valid", c_valid_o, 0);
    chk("c_rst_ready", c_ready, 1);
    chk("c_rst_data", c_data, 0);
    chk("c_rst_last", c_last_o, 0);
    @(negedge clk); c_rst = 1'b0;
    repeat (3) begin
      @(negedge clk); chk("c_discard", c_valid_o, 0);
    end
    @(posedge clk); #1;
    c_valid = 1'b1; c_packed = 12'h123; c_len = 2'd0; c_last = 1'b1;
    @(negedge clk); chk("c2_ready", c_ready, 1);
    @(posedge clk); #1; c_valid = 1'b0;
    @(negedge clk); chk("c2_latency", c_valid_o, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("c2_valid", c_valid_o, 1);
      chk("c2_data", c_data, 3 - k);
      chk("c2_last", c_last_o, (k == 2) ? 1 : 0);
    end
    @(negedge clk); chk("c2_idle", c_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
